// File: rtl/riscv_definitions.sv
// Shared RV32I definitions used by the fetch front end.
package riscv_definitions;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetchState_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a registered head word; clear has priority over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && !clear && (count_q != '0);
        push_ok  = push && !clear && ((count_q != CW'(DEPTH)) || pop_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);

        // The next head is either a stored word or the word being written right now.
        if (count_d == '0) begin
            head_d = head_q;
        end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end

        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            head_d   = head_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = head_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetcher: one outstanding memory request feeding a {pc, inst} queue,
// with redirect flush that drains an in-flight request before restarting.
module fetch_prefetch_queue
    import riscv_definitions::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_instr_ready,
    input  logic [XLEN-1:0]          i_instr_data,
    output logic [3:0]               o_inst_rd_en,
    output logic [XLEN-1:0]          o_inst_addr,
    input  logic                     i_flush,
    input  logic [XLEN-1:0]          i_jump_addr,
    output logic                     o_if_valid,
    output logic [XLEN-1:0]          o_if_inst,
    output logic [XLEN-1:0]          o_if_pc,
    input  logic                     i_id_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetchState_t       state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic [XLEN-1:0]   target, next_pc;
    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count, count_after;
    logic [2*XLEN-1:0] head;

    always_comb begin
        target      = i_jump_addr & ~XLEN'(3);
        next_pc     = fetch_pc_q + XLEN'(4);
        pop         = !fifo_empty && i_id_ready && !i_flush;
        push        = 1'b0;
        count_after = fifo_count + CW'(1) - CW'(pop);
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        addr_d      = addr_q;
        rd_en_d     = rd_en_q;

        case (state_q)
            IDLE: begin
                if (i_flush) begin
                    state_d    = REQ;
                    fetch_pc_d = target;
                    addr_d     = target;
                    rd_en_d    = 1'b1;
                end else if (!fifo_full) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                    rd_en_d = 1'b1;
                end
            end
            REQ: begin
                if (i_flush) begin
                    fetch_pc_d = target;
                    if (i_instr_ready) begin
                        addr_d = target;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (i_instr_ready) begin
                    push       = 1'b1;
                    fetch_pc_d = next_pc;
                    addr_d     = next_pc;
                    // Only keep requesting while a free slot remains for the next word.
                    if (count_after >= CW'(DEPTH)) begin
                        state_d = IDLE;
                        rd_en_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (i_flush) begin
                    fetch_pc_d = target;
                end
                if (i_instr_ready) begin
                    state_d = REQ;
                    addr_d  = i_flush ? target : fetch_pc_q;
                end
            end
            default: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({addr_q, i_instr_data}),
        .pop       (pop),
        .clear     (i_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (head)
    );

    assign o_inst_rd_en = {4{rd_en_q}};
    assign o_inst_addr  = addr_q;
    assign o_if_valid   = !fifo_empty;
    assign o_if_inst    = fifo_empty ? XLEN'(NOP_INSTR) : head[XLEN-1:0];
    assign o_if_pc      = head[2*XLEN-1:XLEN];
    assign o_count      = fifo_count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-level model.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_instr_ready = 1'b0;
    logic [31:0] i_instr_data = '0;
    logic [3:0]  o_inst_rd_en;
    logic [31:0] o_inst_addr;
    logic        i_flush = 1'b0;
    logic [31:0] i_jump_addr = '0;
    logic        o_if_valid;
    logic [31:0] o_if_inst;
    logic [31:0] o_if_pc;
    logic        i_id_ready = 1'b0;
    logic [2:0]  o_count;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_instr_ready (i_instr_ready),
        .i_instr_data  (i_instr_data),
        .o_inst_rd_en  (o_inst_rd_en),
        .o_inst_addr   (o_inst_addr),
        .i_flush       (i_flush),
        .i_jump_addr   (i_jump_addr),
        .o_if_valid    (o_if_valid),
        .o_if_inst     (o_if_inst),
        .o_if_pc       (o_if_pc),
        .i_id_ready    (i_id_ready),
        .o_count       (o_count)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [63:0] mq[$];
    logic [31:0] exp_pc, drain_addr, last_pc;
    bit          draining;
    int          idle_cnt, ws, wait_cnt;
    bit          found;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_pc     = 32'h0;
        draining   = 1'b0;
        drain_addr = 32'h0;
        last_pc    = 32'h0;
        idle_cnt   = 0;
        wait_cnt   = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst           = 1'b1;
        i_flush       = 1'b0;
        i_instr_ready = 1'b0;
        i_id_ready    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_rden",  o_inst_rd_en, 4'h0);
        chk("rst_addr",  o_inst_addr, 32'h0);
        chk("rst_valid", o_if_valid, 1'b0);
        chk("rst_inst",  o_if_inst, NOP);
        chk("rst_pc",    o_if_pc, 32'h0);
        chk("rst_count", o_count, 3'd0);
        model_reset();
    endtask

    // One clock: memory answers from the current request, model advances on the edge.
    task automatic cycle(input bit flush, input logic [31:0] jaddr, input bit idr);
        logic [3:0]  pre_rd;
        logic [31:0] pre_addr;
        bit          rdy;
        @(negedge clk);
        rst      = 1'b0;
        pre_rd   = o_inst_rd_en;
        pre_addr = o_inst_addr;
        if (pre_rd == 4'hF) rdy = (ws < 0) ? ($urandom_range(0, 2) == 0) : (wait_cnt >= ws);
        else rdy = 1'b0;
        i_instr_ready = rdy;
        i_instr_data  = pre_addr ^ 32'hA5A5_0000;
        i_flush       = flush;
        i_jump_addr   = jaddr;
        i_id_ready    = idr;
        @(posedge clk);
        #1;
        if (pre_rd == 4'hF && !rdy) wait_cnt++;
        else wait_cnt = 0;

        if (flush) begin
            mq.delete();
            exp_pc   = jaddr & 32'hFFFF_FFFC;
            draining = (pre_rd == 4'hF) && !rdy;
            if (draining) drain_addr = pre_addr;
        end else begin
            if (idr && mq.size() != 0) void'(mq.pop_front());
            if (pre_rd == 4'hF && rdy) begin
                if (draining) begin
                    draining = 1'b0;
                end else begin
                    chk("push_addr", pre_addr, exp_pc);
                    mq.push_back({pre_addr, pre_addr ^ 32'hA5A5_0000});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        if (mq.size() != 0) last_pc = mq[0][63:32];

        chk("count", o_count, mq.size());
        chk("valid", o_if_valid, mq.size() != 0);
        chk("head_pc", o_if_pc, last_pc);
        chk("head_inst", o_if_inst, (mq.size() != 0) ? mq[0][31:0] : NOP);
        if (draining) begin
            chk("drain_addr", o_inst_addr, drain_addr);
            chk("drain_rden", o_inst_rd_en, 4'hF);
        end else begin
            chk("req_addr", o_inst_addr, exp_pc);
            if (o_inst_rd_en != 4'h0) chk("slot_free", mq.size() < DEPTH, 1'b1);
            idle_cnt = (o_inst_rd_en == 4'h0 && mq.size() < DEPTH) ? idle_cnt + 1 : 0;
            chk("no_stall", idle_cnt <= 1, 1'b1);
            chk("rden_enc", (o_inst_rd_en == 4'h0) || (o_inst_rd_en == 4'hF), 1'b1);
        end
    endtask

    initial begin
        ws = 0;
        model_reset();
        do_reset(2);

        // Zero-wait streaming with decode always ready.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            chk("stream_cnt", o_count <= 3'd1, 1'b1);
            chk("stream_rden", o_inst_rd_en, 4'hF);
        end

        // Decode stalled: queue fills and fetch pauses, then resumes.
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0);
        chk("full_cnt", o_count, 3'd4);
        chk("full_rden", o_inst_rd_en, 4'h0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b1);

        // Three wait states per word.
        ws = 3;
        for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1);

        // Reset in the middle of a request, then redirect while 0x8 is waiting.
        do_reset(1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (o_inst_addr == 32'h8 && o_inst_rd_en == 4'hF) found = 1'b1;
        end
        chk("reach_8", found, 1'b1);
        cycle(1'b1, 32'h0000_0103, 1'b1);
        chk("flush_cnt", o_count, 3'd0);
        chk("flush_valid", o_if_valid, 1'b0);
        chk("drain_hold", o_inst_addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (o_inst_addr == 32'h100 && o_inst_rd_en == 4'hF) found = 1'b1;
        end
        chk("restart_100", found, 1'b1);

        // Flush coinciding with a memory response and a pop.
        ws = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
        chk("pre_valid", o_if_valid, 1'b1);
        cycle(1'b1, 32'h0000_0200, 1'b1);
        chk("coinc_cnt", o_count, 3'd0);
        chk("coinc_addr", o_inst_addr, 32'h200);
        chk("coinc_rden", o_inst_rd_en, 4'hF);

        // Address wrap past the top of memory.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

        // Randomized traffic: random memory latency, decode stalls and redirects.
        ws = -1;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 24) == 0, $urandom, $urandom_range(0, 3) != 0);
        end

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (o_inst_rd_en == 4'hF) found = 1'b1;
        end
        chk("final_req", found, 1'b1);
        do_reset(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Parametrised instruction-fetch front end for the 5-stage RV32I pipeline. It decouples instruction-memory latency from decode by prefetching sequential words into a DEPTH-entry queue of {pc, inst} pairs. Decode pops entries through a valid/ready handshake. An EX-stage redirect flushes the queue and restarts fetch at the jump target. Sits between the instruction memory interface and the ID stage, in place of the single-register fetch stage.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_instr_ready  in  1  memory response valid for the current request; i_instr_data valid this cycle
i_instr_data  in  XLEN  instruction word
o_inst_rd_en  out  4  byte-read enables; 4'hF while a request is active, else 4'h0
o_inst_addr  out  XLEN  fetch address; held stable until i_instr_ready
i_flush  in  1  redirect from EX
i_jump_addr  in  XLEN  redirect target
o_if_valid  out  1  queue head valid
o_if_inst  out  XLEN  head instruction
o_if_pc  out  XLEN  head PC
i_id_ready  in  1  decode accepts head; pop when o_if_valid && i_id_ready
o_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values: o_inst_rd_en=0, o_inst_addr=RESET_PC, o_if_valid=0, o_if_inst=32'h0000_0013 (NOP), o_if_pc=0, o_count=0, state=IDLE, fetch_pc=RESET_PC.
- Reset mid-request: any pending response is ignored. The first request at RESET_PC is issued in the cycle after rst deasserts.
- Only one outstanding request. Memory holds no request state between cycles.
- FSM states:
  - IDLE: no request. Go to REQ when count<DEPTH; o_inst_addr=fetch_pc.
  - REQ: o_inst_rd_en=4'hF.
    - On i_instr_ready without flush: push {o_inst_addr, i_instr_data}; fetch_pc+=4.
    - After the push, stay in REQ with the new address the next cycle if count_next<DEPTH, else go to IDLE.
    - No ready: hold the address.
  - DRAIN: entered on i_flush while REQ has not completed. Keeps the old address and rd_en until i_instr_ready, then discards the data. Next state REQ at the stored target.
- Issue rule: a slot is reserved for the in-flight word, so a push never meets a full queue. Overflow is impossible by construction.
- Throughput: with i_instr_ready tied high, one push per cycle. Sustained back-to-back requests: address n+1 appears the cycle after ready for address n.
- Latency: a pushed word is visible at o_if_* the cycle after the push when the queue was empty (registered FIFO output).
- Pop: on o_if_valid && i_id_ready, the head advances next cycle. Push and pop in the same cycle leave count unchanged.
- Empty queue: o_if_valid=0, o_if_inst=NOP, o_if_pc holds its last value.
- i_flush (highest priority):
  - Next cycle: queue cleared, o_if_valid=0, count=0; pops and pushes in the flush cycle are void.
  - fetch_pc = {i_jump_addr[XLEN-1:2], 2'b00}.
  - In IDLE, or in REQ with i_instr_ready the same cycle: the response is discarded and the next state is REQ at the target.
  - In REQ without ready: go to DRAIN.
  - Flush while in DRAIN: update the stored target and stay in DRAIN.
- Arithmetic: fetch_pc wraps modulo 2^XLEN (32'hFFFF_FFFC+4 -> 0). Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Decomposition:
- Package riscv_definitions gains:
  - NOP_INSTR = 32'h0000_0013
  - typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetchState_t
- Sub-module fetch_fifo: synchronous FIFO with parameters WIDTH and DEPTH; push, pop, clear ports; full/empty/count outputs; registered head.

Test Plan:
- Reset then i_instr_ready=1, i_id_ready=1, data=addr^32'hA5A5_0000 -> addresses 0,4,8,... one per cycle; o_if_pc/o_if_inst match with 1-cycle lag; o_count stays <=1.
- i_id_ready=0, ready=1 with DEPTH=4 -> four pushes (pc 0..C), then o_inst_rd_en=0, o_count=4. Raising i_id_ready restarts fetch at 0x10 with no lost or duplicated words.
- Memory with 3 wait states -> o_inst_addr stable across the wait cycles; one entry per 4 cycles.
- i_flush with i_jump_addr=32'h0000_0103 while the request at 0x8 is waiting -> DRAIN holds 0x8 until ready, word discarded; next request at 0x100; queue empty the cycle after flush.
- i_flush coincident with i_instr_ready and a pop -> neither push nor pop takes effect; count=0; next request at the target.
- RESET_PC=32'hFFFF_FFF8, streaming -> addresses FFF8, FFFC, 0, 4; rst asserted mid-request -> all outputs at reset values next cycle.
